// File: rtl/mips_pkg.sv
// Shared MIPS core definitions.
// Instruction constants, field positions and fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word and its PC
// while decode is stalled.
module fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic [31:0] data,
  output logic [31:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= 32'h0;
      pc    <= 32'h0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      pc    <= in_pc;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, stall skid
// buffer and branch redirect with in-flight discard.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic [5:0]  OPCode
);

  fetch_state_t state;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] target;
  logic        can_accept;
  logic        fire;
  logic        skid_valid;
  logic        skid_load;
  logic        skid_unload;
  logic [31:0] skid_data;
  logic [31:0] skid_pc;

  assign target     = word_align(branch_target);
  assign can_accept = !(if_valid && stall) || branch_taken;
  assign fire       = (state == ST_BUSY) && imem_ready;

  assign skid_load   = fire && !can_accept;
  assign skid_unload = skid_valid && can_accept;

  // DROP keeps the abandoned address on the bus until memory answers
  assign imem_req  = (state != ST_IDLE);
  assign imem_addr = (state == ST_DROP) ? drop_addr : pc;
  assign OPCode    = if_instr[OPC_HI:OPC_LO];

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .unload  (skid_unload),
    .clear   (branch_taken),
    .in_data (imem_rdata),
    .in_pc   (pc),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc      (skid_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      drop_addr <= 32'h0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (branch_taken)
            pc <= target;
          if ((!skid_valid || branch_taken) && can_accept)
            state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (branch_taken) begin
            pc <= target;
            if (!imem_ready) begin
              drop_addr <= pc;
              state     <= ST_DROP;
            end
          end else if (imem_ready) begin
            pc <= pc + 32'd4;
            if (!can_accept)
              state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (branch_taken)
            pc <= target;
          if (imem_ready)
            state <= ST_BUSY;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= 32'h0;
      if_pc4   <= 32'h0;
    end else if (branch_taken) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (can_accept) begin
      if (skid_valid) begin
        if_valid <= 1'b1;
        if_instr <= skid_data;
        if_pc    <= skid_pc;
        if_pc4   <= skid_pc + 32'd4;
      end else if (fire) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_pc4   <= pc + 32'd4;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of per-cycle vectors
// plus hand sequences for reset, wait states and DROP.
module tb_fetch_stage;

  localparam logic [31:0] R   = 32'hBFC0_0000;
  localparam logic [31:0] PAT = 32'hA5A5_5A5A;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic [5:0]  OPCode;

  int checks;
  int failures;
  int lat;
  int cnt;

  fetch_stage #(.RESET_PC(R)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_instr      (if_instr),
    .OPCode        (OPCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ready after lat wait cycles, data = addr ^ PAT
  assign imem_ready = imem_req && (cnt == lat);
  assign imem_rdata = imem_addr ^ PAT;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (!imem_req || imem_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Address must hold while a request waits
  logic        p_req;
  logic        p_rdy;
  logic [31:0] p_addr;
  initial p_req = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_req = 1'b0;
    end else begin
      if (p_req && !p_rdy && imem_req)
        chk("addr_stable", imem_addr, p_addr);
      p_req  = imem_req;
      p_rdy  = imem_ready;
      p_addr = imem_addr;
    end
  end

  task automatic chk_if(input string nm, input logic v,
                        input logic [31:0] pc);
    logic [31:0] ei;
    logic [5:0]  eo;
    ei = v ? (pc ^ PAT) : 32'h0;
    eo = ei[31:26];
    chk({nm, ".valid"}, {31'h0, if_valid}, {31'h0, v});
    chk({nm, ".instr"}, if_instr, ei);
    chk({nm, ".opc"}, {26'h0, OPCode}, {26'h0, eo});
    if (v) begin
      chk({nm, ".pc"}, if_pc, pc);
      chk({nm, ".pc4"}, if_pc4, pc + 32'd4);
    end
  endtask

  task automatic chk_bus(input string nm, input logic req,
                         input logic [31:0] addr);
    chk({nm, ".req"}, {31'h0, imem_req}, {31'h0, req});
    chk({nm, ".addr"}, imem_addr, addr);
  endtask

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        v;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t mk(logic st, logic br, logic [31:0] tgt,
                              logic v, logic [31:0] pc, logic req,
                              logic [31:0] addr);
    vec_t t;
    t.st = st; t.br = br; t.tgt = tgt;
    t.v = v; t.pc = pc; t.req = req; t.addr = addr;
    return t;
  endfunction

  vec_t tv[28];

  initial begin
    checks = 0;
    failures = 0;
    lat = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;

    tv[0]  = mk(0, 0, 0,            0, 0,            1, R);
    tv[1]  = mk(0, 0, 0,            1, R,            1, R + 4);
    tv[2]  = mk(0, 0, 0,            1, R + 4,        1, R + 8);
    tv[3]  = mk(1, 0, 0,            1, R + 4,        0, R + 12);
    tv[4]  = mk(1, 0, 0,            1, R + 4,        0, R + 12);
    tv[5]  = mk(1, 0, 0,            1, R + 4,        0, R + 12);
    tv[6]  = mk(1, 0, 0,            1, R + 4,        0, R + 12);
    tv[7]  = mk(1, 0, 0,            1, R + 4,        0, R + 12);
    tv[8]  = mk(0, 0, 0,            1, R + 8,        0, R + 12);
    tv[9]  = mk(0, 0, 0,            0, 0,            1, R + 12);
    tv[10] = mk(0, 0, 0,            1, R + 12,       1, R + 16);
    tv[11] = mk(0, 0, 0,            1, R + 16,       1, R + 20);
    tv[12] = mk(0, 1, 32'h103,      0, 0,            1, 32'h100);
    tv[13] = mk(0, 0, 0,            1, 32'h100,      1, 32'h104);
    tv[14] = mk(1, 1, 32'h203,      0, 0,            1, 32'h200);
    tv[15] = mk(1, 0, 0,            1, 32'h200,      1, 32'h204);
    tv[16] = mk(1, 0, 0,            1, 32'h200,      0, 32'h208);
    tv[17] = mk(0, 0, 0,            1, 32'h204,      0, 32'h208);
    tv[18] = mk(0, 0, 0,            0, 0,            1, 32'h208);
    tv[19] = mk(0, 0, 0,            1, 32'h208,      1, 32'h20C);
    tv[20] = mk(1, 0, 0,            1, 32'h208,      0, 32'h210);
    tv[21] = mk(1, 1, 32'h300,      0, 0,            1, 32'h300);
    tv[22] = mk(1, 0, 0,            1, 32'h300,      1, 32'h304);
    tv[23] = mk(0, 0, 0,            1, 32'h304,      1, 32'h308);
    tv[24] = mk(0, 1, 32'hFFFF_FFF8, 0, 0,           1, 32'hFFFF_FFF8);
    tv[25] = mk(0, 0, 0,            1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC);
    tv[26] = mk(0, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'h0);
    tv[27] = mk(0, 0, 0,            1, 32'h0,        1, 32'h4);

    repeat (3) @(negedge clk);
    chk_if("reset", 1'b0, 32'h0);
    chk("reset.pc", if_pc, 32'h0);
    chk("reset.pc4", if_pc4, 32'h0);
    chk_bus("reset", 1'b0, R);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      stall = tv[i].st;
      branch_taken = tv[i].br;
      branch_target = tv[i].tgt;
      @(negedge clk);
      chk_if($sformatf("row%0d", i), tv[i].v, tv[i].pc);
      chk_bus($sformatf("row%0d", i), tv[i].req, tv[i].addr);
    end
    stall = 1'b0;
    branch_taken = 1'b0;

    // Reset while a request is outstanding
    lat = 3;
    #2 rst_n = 1'b0;
    #1;
    chk_if("midrst", 1'b0, 32'h0);
    chk("midrst.pc", if_pc, 32'h0);
    chk("midrst.pc4", if_pc4, 32'h0);
    chk_bus("midrst", 1'b0, R);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three wait states: one word per four cycles
    @(negedge clk);
    chk_if("lat.start", 1'b0, 32'h0);
    chk_bus("lat.start", 1'b1, R);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 3) begin
          chk_if($sformatf("lat%0d_%0d", k, c), 1'b1, R + 4 * k);
          chk_bus($sformatf("lat%0d_%0d", k, c), 1'b1, R + 4 * (k + 1));
        end else begin
          chk_if($sformatf("lat%0d_%0d", k, c), 1'b0, 32'h0);
          chk_bus($sformatf("lat%0d_%0d", k, c), 1'b1, R + 4 * k);
        end
      end
    end

    // Branch while waiting: DROP, then a second redirect in DROP
    @(negedge clk);
    chk_bus("drop.pre", 1'b1, R + 12);
    branch_taken = 1'b1;
    branch_target = 32'h0000_0103;
    @(negedge clk);
    chk_if("drop.a", 1'b0, 32'h0);
    chk_bus("drop.a", 1'b1, R + 12);
    branch_target = 32'h0000_0207;
    @(negedge clk);
    chk_if("drop.b", 1'b0, 32'h0);
    chk_bus("drop.b", 1'b1, R + 12);
    branch_taken = 1'b0;
    @(negedge clk);
    chk_if("drop.disc", 1'b0, 32'h0);
    chk_bus("drop.disc", 1'b1, 32'h204);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_if($sformatf("drop.w%0d", c), 1'b0, 32'h0);
      chk_bus($sformatf("drop.w%0d", c), 1'b1, 32'h204);
    end
    @(negedge clk);
    chk_if("drop.tgt", 1'b1, 32'h204);
    chk_bus("drop.tgt", 1'b1, 32'h208);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
